// File: rtl/twiddle_apply8_pkg.sv
// Shared types and arithmetic helpers for the twiddle multiply stage.
// Twiddles are 18-bit signed with 10 fraction bits (1.0 = 1024).
package twiddle_apply8_pkg;

    localparam int TW_W    = 18;
    localparam int TW_FRAC = 10;
    localparam int TW_ONE  = 1024;

    typedef logic [2:0] tw_addr_t;
    typedef logic signed [TW_W-1:0] tw_t;

    // Treat x as an in_w-bit signed value, round half up by dropping
    // TW_FRAC fraction bits, then clamp to an out_w-bit signed range.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] x,
        input int                 in_w,
        input int                 out_w
    );
        logic signed [63:0] xs;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        xs = (x <<< (64 - in_w)) >>> (64 - in_w);
        r  = (xs + (64'sd1 <<< (TW_FRAC - 1))) >>> TW_FRAC;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            res = hi;
        end else if (r < lo) begin
            res = lo;
        end else begin
            res = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/twiddle_apply8_if.sv
// Sample stream into and out of the twiddle multiply stage,
// plus the per-frame step/inv controls that ride with the input.
interface twiddle_apply8_if #(
    parameter int WIDTH = 16
);
    import twiddle_apply8_pkg::*;

    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    tw_addr_t                step;
    logic                    inv;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;

    modport master (
        output di_en, di_re, di_im, step, inv,
        input  do_en, do_re, do_im
    );

    modport slave (
        input  di_en, di_re, di_im, step, inv,
        output do_en, do_re, do_im
    );

endinterface

// File: rtl/Twiddle8.sv
// 8-point twiddle ROM, W8^k = exp(-j*2*pi*k/8) scaled by 1024 and
// floored, with an optional output register selected by TW_FF.
module Twiddle8
    import twiddle_apply8_pkg::*;
#(
    parameter int TW_FF = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  tw_addr_t addr,
    output tw_t      tw_re,
    output tw_t      tw_im
);

    tw_t rom_re;
    tw_t rom_im;

    // Table lookup; entries are floored, hence the -1 residues at 4 and 6
    always_comb begin
        rom_re = '0;
        rom_im = '0;
        unique case (addr)
            3'd0: begin rom_re =  18'sd1024; rom_im =  18'sd0;    end
            3'd1: begin rom_re =  18'sd724;  rom_im = -18'sd725;  end
            3'd2: begin rom_re =  18'sd0;    rom_im = -18'sd1024; end
            3'd3: begin rom_re = -18'sd725;  rom_im = -18'sd725;  end
            3'd4: begin rom_re = -18'sd1024; rom_im = -18'sd1;    end
            3'd5: begin rom_re = -18'sd725;  rom_im =  18'sd724;  end
            3'd6: begin rom_re = -18'sd1;    rom_im =  18'sd1024; end
            3'd7: begin rom_re =  18'sd724;  rom_im =  18'sd724;  end
        endcase
    end

    generate
        if (TW_FF != 0) begin : g_reg
            // Registered ROM output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tw_re <= '0;
                    tw_im <= '0;
                end else begin
                    tw_re <= rom_re;
                    tw_im <= rom_im;
                end
            end
        end else begin : g_comb
            assign tw_re = rom_re;
            assign tw_im = rom_im;
        end
    endgenerate

endmodule

// File: rtl/twiddle_apply8.sv
// Streaming complex multiply by an 8-point twiddle addressed n*step mod 8,
// with optional conjugation, rounding and saturation back to WIDTH.
module twiddle_apply8
    import twiddle_apply8_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TW_FF = 1
) (
    input logic             clk,
    input logic             rst,
    twiddle_apply8_if.slave bus
);

    localparam int PW = WIDTH + TW_W;
    localparam int SW = WIDTH + TW_W + 1;

    logic [2:0] n;
    tw_addr_t   acc;
    tw_addr_t   step_q;
    logic       inv_q;
    logic       frame_start;
    tw_addr_t   addr;
    logic       s_inv;
    tw_t        tw_re;
    tw_t        tw_im;

    assign frame_start = bus.di_en && (n == 3'd0);
    assign addr        = frame_start ? '0 : acc;
    assign s_inv       = frame_start ? bus.inv : inv_q;

    // Frame counter, address accumulator and per-frame step/inv latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n      <= '0;
            acc    <= '0;
            step_q <= '0;
            inv_q  <= 1'b0;
        end else if (bus.di_en) begin
            n <= n + 3'd1;
            if (frame_start) begin
                step_q <= bus.step;
                inv_q  <= bus.inv;
                acc    <= bus.step;
            end else begin
                acc <= acc + step_q;
            end
        end
    end

    Twiddle8 #(
        .TW_FF (TW_FF)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .tw_re (tw_re),
        .tw_im (tw_im)
    );

    logic                    a_v;
    logic                    a_inv;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;

    generate
        if (TW_FF != 0) begin : g_s0
            // S0: data and inv aligned with the registered ROM output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_v   <= 1'b0;
                    a_inv <= 1'b0;
                    a_re  <= '0;
                    a_im  <= '0;
                end else begin
                    a_v   <= bus.di_en;
                    a_inv <= s_inv;
                    a_re  <= bus.di_re;
                    a_im  <= bus.di_im;
                end
            end
        end else begin : g_s0_bypass
            assign a_v   = bus.di_en;
            assign a_inv = s_inv;
            assign a_re  = bus.di_re;
            assign a_im  = bus.di_im;
        end
    endgenerate

    tw_t                  tw_d;
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    logic signed [PW-1:0] ec;
    logic signed [PW-1:0] ed;

    assign tw_d = a_inv ? -tw_im : tw_im;
    assign ea   = PW'(a_re);
    assign eb   = PW'(a_im);
    assign ec   = PW'(tw_re);
    assign ed   = PW'(tw_d);

    logic                 p_v;
    logic signed [PW-1:0] p_ac;
    logic signed [PW-1:0] p_bd;
    logic signed [PW-1:0] p_ad;
    logic signed [PW-1:0] p_bc;

    // S1: the four partial products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v  <= 1'b0;
            p_ac <= '0;
            p_bd <= '0;
            p_ad <= '0;
            p_bc <= '0;
        end else begin
            p_v  <= a_v;
            p_ac <= ea * ec;
            p_bd <= eb * ed;
            p_ad <= ea * ed;
            p_bc <= eb * ec;
        end
    end

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;

    assign sum_re = SW'(p_ac) - SW'(p_bd);
    assign sum_im = SW'(p_ad) + SW'(p_bc);

    // S2: round, saturate and hold the outputs between valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.do_en <= 1'b0;
            bus.do_re <= '0;
            bus.do_im <= '0;
        end else begin
            bus.do_en <= p_v;
            if (p_v) begin
                bus.do_re <= WIDTH'(round_sat(64'(sum_re), SW, WIDTH));
                bus.do_im <= WIDTH'(round_sat(64'(sum_im), SW, WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_twiddle_apply8.sv
// Bench for twiddle_apply8: randomized and directed frames compared
// against a behavioural complex-multiply model with a 3-cycle delay.
module tb_twiddle_apply8;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    twiddle_apply8_if #(.WIDTH(W)) bus ();

    twiddle_apply8 #(
        .WIDTH (W),
        .TW_FF (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int tw_c[8] = '{1024, 724, 0, -725, -1024, -725, -1, 724};
    int tw_d[8] = '{0, -725, -1024, -725, -1, 724, 1024, 724};

    int m_n;
    int m_step;
    bit m_inv;
    bit h_v[3];
    logic signed [W-1:0] h_re[3];
    logic signed [W-1:0] h_im[3];

    logic                exp_en;
    logic signed [W-1:0] exp_re;
    logic signed [W-1:0] exp_im;

    logic signed [W-1:0] q_re[$];
    logic signed [W-1:0] q_im[$];

    function automatic logic signed [W-1:0] rs(input longint x);
        longint r;
        r = (x + 512) >>> 10;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return W'(r);
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_step = 0;
        m_inv = 0;
        for (int i = 0; i < 3; i++) begin
            h_v[i] = 0;
            h_re[i] = '0;
            h_im[i] = '0;
        end
        exp_en = 0;
        exp_re = '0;
        exp_im = '0;
    endtask

    task automatic drive(input bit en, input int re, input int im,
                         input int st, input bit iv);
        longint a, b, c, d;
        int k;
        bus.di_en = en;
        bus.di_re = W'(re);
        bus.di_im = W'(im);
        bus.step = 3'(st);
        bus.inv = iv;
        @(posedge clk);
        #1;
        h_v[2] = h_v[1]; h_re[2] = h_re[1]; h_im[2] = h_im[1];
        h_v[1] = h_v[0]; h_re[1] = h_re[0]; h_im[1] = h_im[0];
        h_v[0] = en;
        if (en) begin
            if (m_n == 0) begin
                m_step = st;
                m_inv = iv;
            end
            k = (m_n * m_step) % 8;
            a = re;
            b = im;
            c = tw_c[k];
            d = m_inv ? -tw_d[k] : tw_d[k];
            h_re[0] = rs(a * c - b * d);
            h_im[0] = rs(a * d + b * c);
            m_n = (m_n + 1) % 8;
        end
        exp_en = h_v[2];
        if (h_v[2]) begin
            exp_re = h_re[2];
            exp_im = h_im[2];
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.di_en = 0; bus.di_re = '0; bus.di_im = '0;
        bus.step = '0; bus.inv = 0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.do_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_en got=%0b want=0", bus.do_en);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.do_re !== 16'sd0) begin
            n_bad++; $display("FAIL reset_re got=%0d want=0", bus.do_re);
        end
        n_cmp++;
        if (bus.do_im !== 16'sd0) begin
            n_bad++; $display("FAIL reset_im got=%0d want=0", bus.do_im);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 11; i++) begin
            drive(i < 8, 1000, -500, 0, 0);
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL identity c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            n_cmp++;
            if (bus.do_en !== (i >= 2 && i < 10)) begin
                n_bad++;
                $display("FAIL identity_lat c%0d got en=%0b", i, bus.do_en);
            end
            if (bus.do_en === 1'b1) begin
                n_cmp++;
                if (bus.do_re !== 16'sd1000 || bus.do_im !== -16'sd500) begin
                    n_bad++;
                    $display("FAIL identity_val c%0d got (%0d,%0d) want (1000,-500)",
                             i, bus.do_re, bus.do_im);
                end
            end
        end
    endtask

    task automatic test_step1();
        q_re.delete(); q_im.delete();
        for (int i = 0; i < 11; i++) begin
            drive(i < 8, 1000, 0, 1, 0);
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL step1 c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            if (bus.do_en === 1'b1) begin
                q_re.push_back(bus.do_re);
                q_im.push_back(bus.do_im);
            end
        end
        n_cmp++;
        if (q_re.size() != 8) begin
            n_bad++; $display("FAIL step1_count got=%0d want=8", q_re.size());
        end
        n_cmp++;
        if (q_re[2] !== 16'sd0 || q_im[2] !== -16'sd1000) begin
            n_bad++; $display("FAIL step1_n2 got (%0d,%0d) want (0,-1000)", q_re[2], q_im[2]);
        end
        n_cmp++;
        if (q_re[4] !== -16'sd1000 || q_im[4] !== -16'sd1) begin
            n_bad++; $display("FAIL step1_n4 got (%0d,%0d) want (-1000,-1)", q_re[4], q_im[4]);
        end
        n_cmp++;
        if (q_re[1] !== 16'sd707 || q_im[1] !== -16'sd708) begin
            n_bad++; $display("FAIL step1_n1 got (%0d,%0d) want (707,-708)", q_re[1], q_im[1]);
        end
    endtask

    task automatic test_conjugate();
        q_re.delete(); q_im.delete();
        for (int i = 0; i < 19; i++) begin
            drive(i < 16, 1000, 0, 1, i < 8);
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL conj c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            if (bus.do_en === 1'b1) begin
                q_re.push_back(bus.do_re);
                q_im.push_back(bus.do_im);
            end
        end
        n_cmp++;
        if (q_re[2] !== 16'sd0 || q_im[2] !== 16'sd1000) begin
            n_bad++; $display("FAIL conj_n2 got (%0d,%0d) want (0,1000)", q_re[2], q_im[2]);
        end
        n_cmp++;
        if (q_re[1] !== 16'sd707 || q_im[1] !== 16'sd708) begin
            n_bad++; $display("FAIL conj_n1 got (%0d,%0d) want (707,708)", q_re[1], q_im[1]);
        end
        n_cmp++;
        if (q_re[10] !== 16'sd0 || q_im[10] !== -16'sd1000) begin
            n_bad++; $display("FAIL conj_next_n2 got (%0d,%0d) want (0,-1000)", q_re[10], q_im[10]);
        end
        n_cmp++;
        if (q_re[9] !== 16'sd707 || q_im[9] !== -16'sd708) begin
            n_bad++; $display("FAIL conj_next_n1 got (%0d,%0d) want (707,-708)", q_re[9], q_im[9]);
        end
    endtask

    task automatic test_saturation();
        int re, im;
        q_re.delete(); q_im.delete();
        for (int i = 0; i < 19; i++) begin
            re = rnd16();
            im = rnd16();
            if (i == 7) begin re = 32767; im = 32767; end
            if (i == 15) begin re = -32768; im = -32768; end
            drive(i < 16, re, im, 1, 0);
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL sat c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            if (bus.do_en === 1'b1) begin
                q_re.push_back(bus.do_re);
                q_im.push_back(bus.do_im);
            end
        end
        n_cmp++;
        if (q_re[7] !== 16'sd0 || q_im[7] !== 16'sd32767) begin
            n_bad++; $display("FAIL sat_pos got (%0d,%0d) want (0,32767)", q_re[7], q_im[7]);
        end
        n_cmp++;
        if (q_re[15] !== 16'sd0 || q_im[15] !== -16'sd32768) begin
            n_bad++; $display("FAIL sat_neg got (%0d,%0d) want (0,-32768)", q_re[15], q_im[15]);
        end
    endtask

    task automatic test_gapped();
        bit en_seen[19];
        q_re.delete(); q_im.delete();
        for (int i = 0; i < 19; i++) begin
            drive(i < 16 && (i % 2 == 0), 1000, 0, 3, 0);
            en_seen[i] = bus.do_en;
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL gapped c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            if (bus.do_en === 1'b1) begin
                q_re.push_back(bus.do_re);
                q_im.push_back(bus.do_im);
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (en_seen[i + 2] != (i % 2 == 0)) begin
                n_bad++;
                $display("FAIL gapped_pattern in%0d got en=%0b want=%0b",
                         i, en_seen[i + 2], (i % 2 == 0));
            end
        end
        n_cmp++;
        if (q_re[1] !== -16'sd708 || q_im[1] !== -16'sd708) begin
            n_bad++; $display("FAIL gapped_a3 got (%0d,%0d) want (-708,-708)", q_re[1], q_im[1]);
        end
        n_cmp++;
        if (q_re[2] !== -16'sd1 || q_im[2] !== 16'sd1000) begin
            n_bad++; $display("FAIL gapped_a6 got (%0d,%0d) want (-1,1000)", q_re[2], q_im[2]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 303; i++) begin
            drive(i < 300 && $urandom_range(0, 3) != 0, rnd16(), rnd16(),
                  int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL random c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        bus.di_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1000, -500, 2, 0);
        end
        rst = 1'b1;
        bus.di_en = 0;
        #1;
        n_cmp++;
        if (bus.do_en !== 1'b0 || bus.do_re !== 16'sd0 || bus.do_im !== 16'sd0) begin
            n_bad++;
            $display("FAIL midreset_async got en=%0b (%0d,%0d) want en=0 (0,0)",
                     bus.do_en, bus.do_re, bus.do_im);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        q_re.delete(); q_im.delete();
        for (int i = 0; i < 14; i++) begin
            drive(i >= 3 && i < 11, 1000, -500, 5, 0);
            n_cmp++;
            if (bus.do_en !== exp_en || bus.do_re !== exp_re || bus.do_im !== exp_im) begin
                n_bad++;
                $display("FAIL midreset c%0d got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                         i, bus.do_en, bus.do_re, bus.do_im, exp_en, exp_re, exp_im);
            end
            if (i < 5) begin
                n_cmp++;
                if (bus.do_en !== 1'b0 || bus.do_re !== 16'sd0) begin
                    n_bad++;
                    $display("FAIL midreset_flush c%0d got en=%0b re=%0d want en=0 re=0",
                             i, bus.do_en, bus.do_re);
                end
            end
            if (bus.do_en === 1'b1) begin
                q_re.push_back(bus.do_re);
                q_im.push_back(bus.do_im);
            end
        end
        n_cmp++;
        if (q_re[0] !== 16'sd1000 || q_im[0] !== -16'sd500) begin
            n_bad++; $display("FAIL midreset_a0 got (%0d,%0d) want (1000,-500)", q_re[0], q_im[0]);
        end
        n_cmp++;
        if (q_re[1] !== -16'sd354 || q_im[1] !== 16'sd1061) begin
            n_bad++; $display("FAIL midreset_a5 got (%0d,%0d) want (-354,1061)", q_re[1], q_im[1]);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_step1();
        test_conjugate();
        test_saturation();
        test_gapped();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
